ysyx_22040931_fetch: RTL

YSYX_22040931_FETCH -- requirements
Module: ysyx_22040931_fetch

---
 rtl/ysyx_22040931_fetch_pkg.sv | 7 +
 rtl/ysyx_22040931_fetch_hold.sv | 52 +++++
 rtl/ysyx_22040931_fetch.sv | 113 +++++++++++
 3 files changed

// File: rtl/ysyx_22040931_fetch_pkg.sv
// Shared widths and constants for the instruction fetch block.
package ysyx_22040931_fetch_pkg;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int DATA_W = 64;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/ysyx_22040931_fetch_hold.sv
// Output register presented to decode: PC, selected instruction word and fault flag.
module ysyx_22040931_fetch_hold
    import ysyx_22040931_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_err,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] instr,
    output logic              fault
);
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] instr_q, instr_d;
    logic              fault_q, fault_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (clear) begin
            pc_d    = '0;
            instr_d = '0;
            fault_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            // A faulting fetch hands decode a harmless NOP alongside the fault flag.
            instr_d = rsp_err ? NOP_INST
                    : (pc_in[2] ? rsp_data[63:32] : rsp_data[31:0]);
            fault_d = rsp_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    assign pc    = pc_q;
    assign instr = instr_q;
    assign fault = fault_q;
endmodule

// File: rtl/ysyx_22040931_fetch.sv
// Instruction fetch: one outstanding doubleword read per PC, result held until decode takes it.
module ysyx_22040931_fetch
    import ysyx_22040931_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic              req_valid,
    output logic [PC_W-1:0]   req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_err,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_instr,
    output logic              out_fault,
    input  logic              out_ready
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fire;
    logic            hold_load;
    logic            hold_clear;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        in_ready   = ~reset & ~flush &
                     ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
        fire       = in_valid & in_ready;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    hold_clear = 1'b1;
                end else if (fire) begin
                    pc_d    = in_pc;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush)          state_d = S_IDLE;
                else if (req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // The read is already in flight, so a flush must still swallow its response.
                if (flush) begin
                    state_d = S_DROP;
                end else if (rsp_valid) begin
                    hold_load = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    hold_clear = 1'b1;
                    state_d    = S_IDLE;
                end else if (out_ready) begin
                    if (fire) begin
                        pc_d    = in_pc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (!flush && rsp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign req_valid = (state_q == S_REQ);
    assign req_addr  = {pc_q[PC_W-1:3], 3'b000};
    assign out_valid = (state_q == S_HOLD);

    ysyx_22040931_fetch_hold u_hold (
        .clock    (clock),
        .reset    (reset),
        .load     (hold_load),
        .clear    (hold_clear),
        .pc_in    (pc_q),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .pc       (out_pc),
        .instr    (out_instr),
        .fault    (out_fault)
    );
endmodule
